// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared FSM encoding, counter width and address check for
//               the memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int CNT_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Misaligned or beyond the populated word range.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mem_array
// Description : Word-addressed synchronous RAM, byte-enable write, registered
//               read. Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Single-outstanding memory responder with fixed wait states,
//               byte-enable stores and address error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       be_q;
    logic             write_q;
    logic             err_q, rd_ok_q;
    logic             enter_d;

    logic             accept_w;
    logic [31:0]      addr_w, wdata_w, arr_rdata_w;
    logic [3:0]       be_w;
    logic             write_w, err_w, commit_w;

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept_w  = req_valid && req_ready;

    // With zero wait states RESP is entered on the acceptance edge itself,
    // before the request fields are latched, so use the live inputs then.
    assign addr_w  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign wdata_w = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign be_w    = (state_q == ST_IDLE) ? req_be    : be_q;
    assign write_w = (state_q == ST_IDLE) ? req_write : write_q;
    assign err_w   = addr_err(addr_w, DEPTH_WORDS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enter_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_w) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        enter_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    enter_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign commit_w = enter_d && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit_w) begin
                err_q   <= err_w;
                rd_ok_q <= !write_w && !err_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept_w) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            write_q <= req_write;
        end
    end

    mem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem_array (
        .clk     (clk),
        .we_i    (commit_w && write_w && !err_w),
        .re_i    (commit_w && !write_w && !err_w),
        .addr_i  (addr_w[AW+1:2]),
        .wdata_i (wdata_w),
        .be_i    (be_w),
        .rdata_o (arr_rdata_w)
    );

    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && rd_ok_q) ? arr_rdata_w : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Directed self-checking bench for mem_responder (2 and 0 waits).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    logic        z_req_valid, z_req_write, z_resp_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    int tot = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    // Drives one request to completion; request fields are scrambled after
    // acceptance so a design that keeps sampling them is caught.
    task automatic access(input bit sel, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        if (sel) begin
            z_req_valid = 1'b1; z_req_write = wr; z_req_addr = addr; z_req_wdata = wd; z_req_be = be;
        end else begin
            req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_be = be;
        end
        n = 0;
        while (((sel ? z_req_ready : req_ready) !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        if (sel) begin
            z_req_valid = 1'b0; z_req_write = ~wr; z_req_addr = ~addr; z_req_wdata = ~wd; z_req_be = ~be;
        end else begin
            req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_wdata = ~wd; req_be = ~be;
        end
        lat = 1;
        while (((sel ? z_resp_valid : resp_valid) !== 1'b1) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd = sel ? z_resp_rdata : resp_rdata;
        er = sel ? z_resp_err : resp_err;
        if (sel) z_resp_ready = 1'b1; else resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        z_resp_ready = 1'b0;
        resp_ready   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tot++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        tot++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        tot++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            bad++; $display("FAIL reset_resp got=%h/%b exp=00000000/0", resp_rdata, resp_err); end
        tot++; if (z_req_ready !== 1'b0) begin bad++; $display("FAIL reset_z_req_ready got=%b exp=0", z_req_ready); end
        reset = 1'b0;
        @(negedge clk);
        tot++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        tot++; if (lat != 3) begin bad++; $display("FAIL store_latency got=%0d exp=3", lat); end
        tot++; if (er !== 1'b0 || rd !== 32'h0) begin
            bad++; $display("FAIL store_resp got=%h/%b exp=00000000/0", rd, er); end
        access(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        tot++; if (lat != 3) begin bad++; $display("FAIL load_latency got=%0d exp=3", lat); end
        tot++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            bad++; $display("FAIL load_10 got=%h/%b exp=deadbeef/0", rd, er); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        access(0, 1, 32'h10, 32'h11223344, 4'b0101, rd, er, lat);
        access(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        tot++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be_0101 got=%h exp=de22be44", rd); end
        access(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        tot++; if (er !== 1'b0) begin bad++; $display("FAIL be_0000_err got=%b exp=0", er); end
        access(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        tot++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be_0000_data got=%h exp=de22be44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        access(0, 1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        access(0, 0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        tot++; if (er !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL misaligned_load got=%h/%b exp=00000000/1", rd, er); end
        tot++; if (lat != 3) begin bad++; $display("FAIL err_latency got=%0d exp=3", lat); end
        access(0, 1, 32'h400, 32'h5A5A5A5A, 4'hF, rd, er, lat);
        tot++; if (er !== 1'b1) begin bad++; $display("FAIL oob_store_err got=%b exp=1", er); end
        access(0, 0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        tot++; if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
            bad++; $display("FAIL word0_after_oob got=%h/%b exp=a5a5a5a5/0", rd, er); end
        access(0, 1, 32'h3FC, 32'h0BADF00D, 4'hF, rd, er, lat);
        access(0, 0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        tot++; if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            bad++; $display("FAIL last_word got=%h/%b exp=0badf00d/0", rd, er); end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (resp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        tot++; if (n != 3) begin bad++; $display("FAIL bp_latency got=%0d exp=3", n); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tot++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDE22BE44 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] valid=%b rdata=%h ready=%b exp=1/de22be44/0",
                         i, resp_valid, resp_rdata, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        tot++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release ready=%b valid=%b exp=1/0", req_ready, resp_valid); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat;
        bit seen;
        access(0, 1, 32'h20, 32'h12345678, 4'hF, rd, er, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tot++; if (req_ready !== 1'b0) begin bad++; $display("FAIL wait_req_ready got=%b exp=0", req_ready); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        tot++; if (seen) begin bad++; $display("FAIL aborted_resp got=1 exp=0"); end
        access(0, 0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        tot++; if (rd !== 32'h12345678) begin bad++; $display("FAIL aborted_store got=%h exp=12345678", rd); end
    endtask

    task automatic test_wait0();
        logic [31:0] rd; logic er; int lat;
        access(1, 1, 32'h8, 32'h600DCAFE, 4'hF, rd, er, lat);
        tot++; if (lat != 1 || er !== 1'b0) begin
            bad++; $display("FAIL w0_store got lat=%0d err=%b exp=1/0", lat, er); end
        access(1, 0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        tot++; if (lat != 1) begin bad++; $display("FAIL w0_load_latency got=%0d exp=1", lat); end
        tot++; if (rd !== 32'h600DCAFE) begin bad++; $display("FAIL w0_load_data got=%h exp=600dcafe", rd); end
        access(1, 0, 32'h40, 32'h0, 4'h0, rd, er, lat);
        tot++; if (er !== 1'b1 || rd !== 32'h0 || lat != 1) begin
            bad++; $display("FAIL w0_oob got=%h/%b lat=%0d exp=00000000/1 lat=1", rd, er, lat); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0; z_resp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        test_wait0();
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, the number of 32-bit words of storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, the number of wait states inserted per access (0..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, the initiator request is present.
REQ-006 SHALL have port req_ready, output, 1, the responder accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32, the byte address.
REQ-009 SHALL have port req_wdata, input, 32, the store data.
REQ-010 SHALL have port req_be, input, 4, the store byte enables; bit i selects bits [8i+7:8i].
REQ-011 SHALL have port resp_valid, output, 1, a response is present.
REQ-012 SHALL have port resp_ready, input, 1, the initiator accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32, the load data.
REQ-014 SHALL have port resp_err, output, 1, the access was rejected.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE and never while reset is high; resp_valid = 1 only in RESP.
REQ-017 SHALL treat req_valid & req_ready at an edge as acceptance: latch addr/write/wdata/be, load the wait counter with WAIT_CYCLES, and go to WAIT, or go to RESP when WAIT_CYCLES = 0.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and move to RESP on the edge where the counter equals 1; resp_valid SHALL first assert exactly WAIT_CYCLES+1 cycles after the acceptance edge.
REQ-019 SHALL commit a store, and register load data, on the edge that enters RESP, and only then.
REQ-020 SHALL write only enabled bytes on a store; be = 0000 leaves memory unchanged and returns resp_err = 0.
REQ-021 SHALL return resp_rdata = 0 for stores.
REQ-022 SHALL treat req_addr[1:0] != 0, or word index req_addr[31:2] >= DEPTH_WORDS, as an error: resp_err = 1, resp_rdata = 0, no memory change; the timing stays the same as a normal access.
REQ-023 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1; on that edge it returns to IDLE.
REQ-024 SHALL NOT accept back-to-back requests in one cycle; a new request is accepted no earlier than the cycle after the response handshake.
REQ-025 SHALL ignore req_* changes after acceptance.

Reset
REQ-026 SHALL, while reset is high at an edge, force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0.
REQ-027 SHALL, on reset mid-operation (WAIT or RESP), abandon the operation; a store still in WAIT SHALL NOT be committed.
REQ-028 SHALL NOT reset memory contents.

Structure
REQ-029 SHALL place the state enumeration and the WAIT_CYCLES counter width (4) in the shared package mem_pkg.
REQ-030 SHALL instantiate one sub-module, mem_array: a word-addressed synchronous RAM with 4-bit byte-enable write and a registered read.

Verification
REQ-031 SHALL test a store: addr 0x10, wdata 0xDEADBEEF, be 1111, WAIT_CYCLES 2 -> resp_valid 3 cycles after acceptance, err 0; a following load of 0x10 returns 0xDEADBEEF.
REQ-032 SHALL test a byte-enable store: store 0x11223344 with be 0101 over 0xDEADBEEF at 0x10 -> a load returns 0xDE22BE44.
REQ-033 SHALL test errors: load 0x13 -> err 1, rdata 0; store to 0x400 with DEPTH_WORDS 256 -> err 1, and a load of 0x0 is unchanged.
REQ-034 SHALL test backpressure: hold resp_ready 0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready 0; release -> IDLE and req_ready 1 the next cycle.
REQ-035 SHALL test reset in WAIT: store 0xCAFEF00D to 0x20, assert reset on the first WAIT cycle -> a later load of 0x20 returns the old value, and no resp_valid for the aborted request.
REQ-036 SHALL test WAIT_CYCLES = 0: a load is answered 1 cycle after acceptance.
